median_frame_ctrl: RTL
======================

Name: median_frame_ctrl

Overview:
- Frame-level sequencer for the 3x3 median filter datapath.
- On a start pulse it reads one grayscale frame from a synchronous source RAM in raster order and streams it into the filter as pixel_in/valid_in.
- It discards the filter's window-priming outputs and writes each remaining median result to a destination RAM at a sequential address.
- It reports busy/done and flags protocol errors; it sits between the frame buffers and the filter instance.

Parameters:
- IMG_W, 64, frame width in pixels.
- IMG_H, 64, frame height in pixels.
- ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- PRIME, 8, number of leading filter results discarded per frame (window fill).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle frame start request
- hold  in  1  source throttle; while high no new RAM read is issued
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky protocol error flag, cleared by rst or accepted start
- rd_en  out  1  source RAM read strobe
- rd_addr  out  ADDR_W  source RAM read address
- rd_data  in  8  source RAM data, valid exactly 1 cycle after rd_en
- flt_pixel  out  8  to filter pixel_in
- flt_valid  out  1  to filter valid_in
- flt_result  in  8  from filter pixel_out
- flt_result_valid  in  1  from filter valid_out, 1 cycle after flt_valid
- wr_en  out  1  destination RAM write strobe
- wr_addr  out  ADDR_W  destination RAM write address
- wr_data  out  8  destination RAM write data

Behaviour:
- Reset: synchronous, active-high; all outputs 0; FSM to IDLE; all counters 0. Reset mid-frame aborts immediately with no done pulse, and the first cycle after deassertion is IDLE.
- N = IMG_W*IMG_H. FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 -> FETCH; busy=1 from the next cycle; rd counter=0, result counter=0, write counter=0, err cleared.
- FETCH, each cycle:
  - If hold=0: rd_en=1, rd_addr=rd counter, counter+1.
  - If hold=1: rd_en=0 and the counter holds.
  - After the read with address N-1 is issued -> DRAIN.
- Filter feed (registered from the RAM return): flt_valid = rd_en delayed 1 cycle; flt_pixel = rd_data sampled in that cycle. flt_valid is never high without a matching prior rd_en.
- Result handling: on each flt_result_valid, the result counter increments.
  - While the counter is < PRIME, the result is dropped (wr_en=0).
  - Otherwise, in the same cycle: wr_en=1, wr_data=flt_result, wr_addr=write counter, write counter+1.
  - Exactly N-PRIME writes per frame, addresses 0..N-PRIME-1.
- DRAIN: wait until the write counter reaches N-PRIME (pipeline depth 2 cycles after the last rd_en) -> DONE. hold is ignored in DRAIN.
- DONE: done=1 for one cycle, busy=0 in that same cycle -> IDLE.
- Latency: start to first rd_en = 1 cycle. rd_en to flt_valid = 1 cycle. flt_valid to write = 1 cycle (via filter). With hold=0 throughout, start to done = N+4 cycles.
- start while busy: ignored with no effect. start in the DONE cycle: ignored.
- err is set (sticky) on any of:
  - flt_result_valid=1 in IDLE;
  - the result counter exceeding N in the current frame.
  - Errors never change FSM flow.
- hold toggling never drops or duplicates a pixel; reads resume at the next address.
- Counters are ADDR_W+1 bits wide internally; no wrap within a frame.

Test Plan:
- IMG_W=4, IMG_H=4, PRIME=8, source = 0..15, hold=0, start pulse -> rd_addr 0..15 on consecutive cycles; 8 writes at wr_addr 0..7; done exactly 20 cycles after start; busy high for 19 cycles.
- Same frame with hold high for 3 cycles after the 5th read -> no rd_en during hold; rd_addr resumes at 5; wr_data sequence identical to the no-hold run; done delayed by 3 cycles.
- Source all 0 except a single 255 impulse at addr 9 -> every wr_data = 0 (impulse rejected); exactly 8 writes.
- start asserted again at cycle 6 of a frame -> ignored: one done pulse, write count still 8, err=0.
- rst asserted while in FETCH at rd_addr=7 -> next cycle all outputs 0, no done; new start runs a full clean frame from addr 0.
- Bench injects flt_result_valid=1 while IDLE -> err=1 and stays 1; the next accepted start clears err.

Source files
------------

// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: streams one frame from source RAM through the median filter and writes its results.
module median_frame_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int PRIME  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        flt_pixel,
    output logic              flt_valid,
    input  logic [7:0]        flt_result,
    input  logic              flt_result_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);
    localparam logic [ADDR_W:0] N_L    = (ADDR_W+1)'(IMG_W*IMG_H);
    localparam logic [ADDR_W:0] LAST   = (ADDR_W+1)'(IMG_W*IMG_H-1);
    localparam logic [ADDR_W:0] WR_END = (ADDR_W+1)'(IMG_W*IMG_H-PRIME);
    localparam logic [ADDR_W:0] P_L    = (ADDR_W+1)'(PRIME);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state, nxt;
    logic [ADDR_W:0] rd_cnt, res_cnt, wr_cnt;
    logic            accept, result, keep;

    always_comb begin
        accept    = state == IDLE && start;
        busy      = state == FETCH || state == DRAIN;
        done      = state == DONE;
        rd_en     = state == FETCH && !hold;
        rd_addr   = rd_en ? rd_cnt[ADDR_W-1:0] : '0;
        flt_pixel = flt_valid ? rd_data : '0;
        result    = busy && flt_result_valid;
        keep      = result && res_cnt >= P_L;
        wr_en     = keep;
        wr_addr   = keep ? wr_cnt[ADDR_W-1:0] : '0;
        wr_data   = keep ? flt_result : '0;
        nxt = state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? (rd_en && rd_cnt == LAST ? DRAIN : FETCH) :
              state == DRAIN ? (wr_cnt == WR_END ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            res_cnt   <= '0;
            wr_cnt    <= '0;
            flt_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt;
            flt_valid <= rd_en;
            if (accept) begin
                rd_cnt  <= '0;
                res_cnt <= '0;
                wr_cnt  <= '0;
            end
            if (rd_en) rd_cnt <= rd_cnt + ONE;
            if (result) res_cnt <= res_cnt + ONE;
            if (keep) wr_cnt <= wr_cnt + ONE;
            // a result arriving while idle, or beyond the frame's pixel count, is a protocol error
            err <= (err && !accept) || (flt_result_valid && state == IDLE) || (result && res_cnt >= N_L);
        end
    end
endmodule
